// File: rtl/aes_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aes_ctrl_pkg
// Shared definitions for the AES-128 round sequencer:
//   - ctrl_state_e : sequencer states (IDLE, ROUND, HOLD)
//   - NR_DEFAULT   : number of rounds for full AES-128
//   - RCON         : key-expansion round constants, indexed by round 1..10
// -----------------------------------------------------------------------------
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } ctrl_state_e;

    localparam int NR_DEFAULT = 10;

    // Index range of the RCON table; rounds outside it have no constant.
    localparam int RCON_FIRST = 1;
    localparam int RCON_LAST  = 10;

    localparam logic [7:0] RCON [RCON_FIRST:RCON_LAST] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

endpackage

// File: rtl/aes_rcon_lut.sv
// -----------------------------------------------------------------------------
// aes_rcon_lut
// Combinational round-number to round-constant lookup.
// Ports:
//   round_i [ROUND_W-1:0] : round number; 1..10 map to RCON, anything else -> 0
//   rcon_o  [7:0]         : round constant for the key-expansion step
// -----------------------------------------------------------------------------
module aes_rcon_lut
    import aes_ctrl_pkg::*;
#(
    parameter int ROUND_W = 4
) (
    input  logic [ROUND_W-1:0] round_i,
    output logic [7:0]         rcon_o
);

    // One masked term per table entry; at most one term is non-zero, so an
    // OR-reduction yields the selected constant or 0 when out of range.
    logic [7:0] term [RCON_FIRST:RCON_LAST];

    genvar gi;
    generate
        for (gi = RCON_FIRST; gi <= RCON_LAST; gi++) begin : g_entry
            // Zero-extend before comparing so narrow ROUND_W never aliases.
            assign term[gi] = (32'(round_i) == gi) ? RCON[gi] : 8'h00;
        end
    endgenerate

    always_comb begin
        rcon_o = 8'h00;
        for (int i = RCON_FIRST; i <= RCON_LAST; i++) begin
            rcon_o = rcon_o | term[i];
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
// Iterative sequencer for a single-round AES-128 encryption datapath. Accepts
// a block over in_valid/in_ready, steps the datapath through NR rounds, then
// presents the result over out_valid/out_ready. No 128-bit data is held here.
//
// Parameters:
//   NR      : rounds per block (1..10; <10 only for reduced-round testing)
//   ROUND_W : width of the round index, 2^ROUND_W > NR
//
// Ports:
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  : block input handshake
//   abort              : synchronous cancel of the block in flight
//   out_valid/out_ready: ciphertext output handshake
//   dp_load            : datapath captures IN^KEY / KEY at this edge
//   dp_round_en        : datapath executes one round at this edge
//   dp_final           : current round omits MixColumns
//   dp_round           : current round 1..NR, 0 outside a round
//   dp_rcon            : round constant, 0 outside a round
//   busy               : high in ROUND or HOLD
//   blk_count          : completed output handshakes (only when
//                        AES_ROUND_CTRL_PERF_EN is defined)
// -----------------------------------------------------------------------------
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR      = NR_DEFAULT,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               dp_load,
    output logic               dp_round_en,
    output logic               dp_final,
    output logic [ROUND_W-1:0] dp_round,
    output logic [7:0]         dp_rcon,
    output logic               busy
`ifdef AES_ROUND_CTRL_PERF_EN
    ,
    output logic [31:0]        blk_count
`endif
);

    localparam logic [ROUND_W-1:0] RND_ZERO = '0;
    localparam logic [ROUND_W-1:0] RND_ONE  = ROUND_W'(1);
    localparam logic [ROUND_W-1:0] RND_LAST = ROUND_W'(NR);

    ctrl_state_e        state_q, state_d;
    logic [ROUND_W-1:0] rnd_q, rnd_d;
    logic [7:0]         lut_rcon;

    aes_rcon_lut #(
        .ROUND_W (ROUND_W)
    ) u_rcon_lut (
        .round_i (rnd_q),
        .rcon_o  (lut_rcon)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rnd_q   <= RND_ZERO;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        dp_load     = 1'b0;
        dp_round_en = 1'b0;
        dp_final    = 1'b0;
        dp_round    = RND_ZERO;
        dp_rcon     = 8'h00;
        busy        = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = !abort;
                if (in_valid && !abort) begin
                    dp_load = 1'b1;
                    state_d = ROUND;
                    rnd_d   = RND_ONE;
                end
            end

            ROUND: begin
                busy = 1'b1;
                if (abort) begin
                    // Cancelled round: datapath must not move this edge.
                    state_d = IDLE;
                    rnd_d   = RND_ZERO;
                end else begin
                    dp_round_en = 1'b1;
                    dp_round    = rnd_q;
                    dp_rcon     = lut_rcon;
                    dp_final    = (rnd_q == RND_LAST);
                    if (rnd_q == RND_LAST) begin
                        state_d = HOLD;
                    end else begin
                        rnd_d = rnd_q + RND_ONE;
                    end
                end
            end

            HOLD: begin
                busy = 1'b1;
                if (abort) begin
                    // out_valid is withdrawn in the abort cycle so a consumer
                    // with out_ready high never sees a completed handshake.
                    state_d = IDLE;
                    rnd_d   = RND_ZERO;
                end else begin
                    out_valid = 1'b1;
                    in_ready  = out_ready;
                    if (out_ready) begin
                        if (in_valid) begin
                            // Back-to-back: next block loads as this one leaves.
                            dp_load = 1'b1;
                            state_d = ROUND;
                            rnd_d   = RND_ONE;
                        end else begin
                            state_d = IDLE;
                            rnd_d   = RND_ZERO;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                rnd_d   = RND_ZERO;
            end
        endcase

        // While reset is asserted nothing is offered or accepted.
        if (reset) begin
            in_ready    = 1'b0;
            out_valid   = 1'b0;
            dp_load     = 1'b0;
            dp_round_en = 1'b0;
            dp_final    = 1'b0;
            dp_round    = RND_ZERO;
            dp_rcon     = 8'h00;
            busy        = 1'b0;
        end
    end

`ifdef AES_ROUND_CTRL_PERF_EN
    logic [31:0] blk_count_q;

    // Counts only completed handshakes; out_valid is already low on abort,
    // and the add wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_count_q <= 32'd0;
        end else if (out_valid && out_ready) begin
            blk_count_q <= blk_count_q + 32'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule
